wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the MEM/WB pipeline writeback and
//  a multi-cycle unit (divider/multiplier) result stream. Pipeline writeback always wins.

---
 rtl/wb_port_arbiter.sv | 125 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, multi-cycle results queue.
// Optional WB_FWD_EN forwards the youngest queued result for a matching read address.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_wreg,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_wd,
    input  logic [DATA_W-1:0] mc_wdata,
    output logic              mc_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stallreq,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              pend_hit,
    output logic              fwd_valid,
    output logic [DATA_W-1:0] fwd_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [ADDR_W-1:0] q_wd   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_nx;
    logic [SW-1:0]     starve_cnt, starve_nx;
    logic              full, empty, pwb, push_acc, push, pop;
    logic              hit_q;
    logic [PW-1:0]     idx;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign mc_ready = !full;
    assign pwb      = wb_wreg && (wb_wd != '0);
    assign push_acc = mc_valid && mc_ready;
    assign push     = push_acc && (mc_wd != '0);
    assign pop      = !pwb && !empty;
    assign count_nx = count + CW'(push) - CW'(pop);

    always_comb begin
        starve_nx = starve_cnt;
        if (count_nx == '0 || pop)
            starve_nx = '0;
        else if (pwb && !empty && starve_cnt < SW'(STARVE_LIM))
            starve_nx = starve_cnt + 1'b1;
    end

    // Scan oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit_q    = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count && q_wd[idx] == q_addr) begin
                hit_q = 1'b1;
`ifdef WB_FWD_EN
                fwd_data = q_data[idx];
`endif
            end
        end
`ifdef WB_FWD_EN
        if (push && mc_wd == q_addr)
            fwd_data = mc_wdata;
`endif
    end

    assign pend_hit = (q_addr != '0) &&
                      (hit_q || (push && mc_wd == q_addr));

`ifdef WB_FWD_EN
    assign fwd_valid = pend_hit;
`else
    assign fwd_valid = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            q_wd[wr_ptr]   <= mc_wd;
            q_data[wr_ptr] <= mc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            stallreq   <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count      <= count_nx;
            starve_cnt <= starve_nx;
            stallreq   <= (count_nx == CW'(DEPTH)) ||
                          (starve_nx >= SW'(STARVE_LIM));
            if (pwb) begin
                rf_we    <= 1'b1;
                rf_waddr <= wb_wd;
                rf_wdata <= wb_wdata;
            end else if (pop) begin
                rf_we    <= 1'b1;
                rf_waddr <= q_wd[rd_ptr];
                rf_wdata <= q_data[rd_ptr];
            end else begin
                rf_we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (default parameters).
// Expectations adapt to WB_FWD_EN when the macro is defined for the build.
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        mc_valid;
    logic [4:0]  mc_wd;
    logic [31:0] mc_wdata;
    logic        mc_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stallreq;
    logic [4:0]  q_addr;
    logic        pend_hit;
    logic        fwd_valid;
    logic [31:0] fwd_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk(clk), .rst(rst),
        .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
        .mc_valid(mc_valid), .mc_wd(mc_wd), .mc_wdata(mc_wdata),
        .mc_ready(mc_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stallreq(stallreq), .q_addr(q_addr), .pend_hit(pend_hit),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] a,
                      input logic [31:0] d);
        wb_wreg = en; wb_wd = a; wb_wdata = d;
    endtask

    task automatic mc(input logic v, input logic [4:0] a,
                      input logic [31:0] d);
        mc_valid = v; mc_wd = a; mc_wdata = d;
    endtask

    task automatic chk_rf(input string tag, input logic we,
                          input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".we"}, 32'(rf_we), 32'(we));
        if (we) begin
            chk({tag, ".addr"}, 32'(rf_waddr), 32'(a));
            chk({tag, ".data"}, rf_wdata, d);
        end
    endtask

    logic fwd_on;

    initial begin
`ifdef WB_FWD_EN
        fwd_on = 1'b1;
`else
        fwd_on = 1'b0;
`endif
        rst = 1'b0;
        wb(0, 0, 0);
        mc(0, 0, 0);
        q_addr = 5'd7;

        // reset held with clocks running
        repeat (3) tick;
        chk("rst.we", 32'(rf_we), 0);
        chk("rst.stall", 32'(stallreq), 0);
        chk("rst.ready", 32'(mc_ready), 1);
        chk("rst.hit", 32'(pend_hit), 0);
        rst = 1'b1;
        tick;
        chk("rel.we", 32'(rf_we), 0);
        chk("rel.stall", 32'(stallreq), 0);
        chk("rel.ready", 32'(mc_ready), 1);

        // plain pipeline writeback
        wb(1, 3, 32'h11);
        tick;
        wb(0, 0, 0);
        chk_rf("wb", 1, 3, 32'h11);
        tick;
        chk_rf("wb.idle", 0, 0, 0);
        chk("wb.hold", 32'(rf_waddr), 3);

        // single queued result drains on idle slot
        mc(1, 7, 32'hAA);
        #1;
        chk("mc.hit_push", 32'(pend_hit), 1);
        tick;
        mc(0, 0, 0);
        #1;
        chk("mc.hit_q", 32'(pend_hit), 1);
        chk_rf("mc.nobypass", 0, 0, 0);
        tick;
        chk_rf("mc.pop", 1, 7, 32'hAA);
        chk("mc.hit_gone", 32'(pend_hit), 0);
        tick;
        chk_rf("mc.idle", 0, 0, 0);

        // fill FIFO under continuous writeback, then drain in order
        wb(1, 1, 32'h100);
        mc(1, 5, 32'h1);
        tick;
        chk("fill.stall1", 32'(stallreq), 0);
        mc(1, 6, 32'h2);
        tick;
        mc(0, 0, 0);
        #1;
        chk("fill.ready", 32'(mc_ready), 0);
        chk("fill.stall", 32'(stallreq), 1);
        chk_rf("fill.wbwins", 1, 1, 32'h100);
        wb(0, 0, 0);
        tick;
        chk_rf("drain.5", 1, 5, 32'h1);
        chk("drain.ready", 32'(mc_ready), 1);
        tick;
        chk_rf("drain.6", 1, 6, 32'h2);
        chk("drain.stall", 32'(stallreq), 0);
        tick;
        chk_rf("drain.idle", 0, 0, 0);

        // starvation: entry blocked by writeback
        wb(1, 2, 32'h22);
        mc(1, 12, 32'h33);
        tick;
        mc(0, 0, 0);
        repeat (3) tick;
        chk("starve.3", 32'(stallreq), 0);
        tick;
        chk("starve.4", 32'(stallreq), 1);
        tick;
        chk("starve.sat", 32'(stallreq), 1);
        wb(0, 0, 0);
        tick;
        chk_rf("starve.pop", 1, 12, 32'h33);
        chk("starve.clr", 32'(stallreq), 0);

        // same-address entries: forwarding and order
        wb(1, 4, 32'h44);
        q_addr = 5'd9;
        mc(1, 9, 32'h5);
        tick;
        mc(1, 9, 32'h6);
        #1;
        chk("fwd.pushv", 32'(fwd_valid), 32'(fwd_on));
        chk("fwd.pushd", fwd_data, fwd_on ? 32'h6 : 32'h0);
        tick;
        mc(0, 0, 0);
        #1;
        chk("fwd.hit", 32'(pend_hit), 1);
        chk("fwd.valid", 32'(fwd_valid), 32'(fwd_on));
        chk("fwd.data", fwd_data, fwd_on ? 32'h6 : 32'h0);
        wb(0, 0, 0);
        tick;
        chk_rf("same.old", 1, 9, 32'h5);
        chk("same.hit", 32'(pend_hit), 1);
        chk("same.fwd", fwd_data, fwd_on ? 32'h6 : 32'h0);
        tick;
        chk_rf("same.new", 1, 9, 32'h6);
        chk("same.nohit", 32'(pend_hit), 0);

        // address zero is discarded
        q_addr = 5'd0;
        mc(1, 0, 32'h77);
        #1;
        chk("zero.hit", 32'(pend_hit), 0);
        tick;
        mc(0, 0, 0);
        tick;
        chk_rf("zero.nowr", 0, 0, 0);
        chk("zero.ready", 32'(mc_ready), 1);

        // reset with two queued entries
        wb(1, 8, 32'h88);
        mc(1, 10, 32'h1);
        tick;
        mc(1, 11, 32'h2);
        tick;
        mc(0, 0, 0);
        q_addr = 5'd10;
        #1;
        chk("rq.hit", 32'(pend_hit), 1);
        chk("rq.ready", 32'(mc_ready), 0);
        rst = 1'b0;
        #1;
        chk("rq.ready0", 32'(mc_ready), 1);
        chk("rq.hit0", 32'(pend_hit), 0);
        chk("rq.stall0", 32'(stallreq), 0);
        chk("rq.we0", 32'(rf_we), 0);
        wb(0, 0, 0);
        tick;
        rst = 1'b1;
        tick;
        chk_rf("rq.empty", 0, 0, 0);
        tick;
        chk_rf("rq.empty2", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
